if_stage: RTL and testbench



---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 119 +++++++++++
 tb/tb_if_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bundles the fetch stage's control, instruction-memory and IF/ID signals.
// The master modport is the fetch stage; the slave modport is everything around it.
interface if_stage_if;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] ifid_inst_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic        fault_o;
  logic [31:0] fetch_count_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
    output imem_addr_o, ifid_inst_o, ifid_pc_o, ifid_pc4_o, ifid_valid_o,
           fault_o, fetch_count_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
    input  imem_addr_o, ifid_inst_o, ifid_pc_o, ifid_pc4_o, ifid_valid_o,
           fault_o, fetch_count_o
  );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, IF/ID pipeline register and a
// sticky fault state entered when a redirect target is not word-aligned.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal fetch; honours redirect > flush > stall > advance
// ST_FAULT | misaligned redirect seen; PC/count frozen, IF/ID bubbled
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0033
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        bubble;
  logic        redirect_misaligned;

  assign pc_plus4            = pc_q + 32'd4;
  assign redirect_misaligned = (bus.redirect_pc_i[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    fault_d      = fault_q;
    count_d      = count_q;
    bubble       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bus.redirect_i) begin
          bubble = 1'b1;
          if (redirect_misaligned) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = bus.redirect_pc_i;
          end
        end else if (bus.flush_i) begin
          bubble = 1'b1;
          if (!bus.stall_i) begin
            pc_d = pc_plus4;
          end
        end else if (!bus.stall_i) begin
          ifid_inst_d  = bus.imem_data_i;
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          count_d      = count_q + 32'd1;
        end
      end
      ST_FAULT: begin
        bubble = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Bubbles still record the current PC so a debugger can see where fetch sat.
    if (bubble) begin
      ifid_inst_d  = NOP_INST;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      ifid_inst_q  <= NOP_INST;
      ifid_pc_q    <= 32'd0;
      ifid_pc4_q   <= 32'd4;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      fault_q      <= fault_d;
      count_q      <= count_d;
    end
  end

  assign bus.imem_addr_o   = pc_q[7:2];
  assign bus.ifid_inst_o   = ifid_inst_q;
  assign bus.ifid_pc_o     = ifid_pc_q;
  assign bus.ifid_pc4_o    = ifid_pc4_q;
  assign bus.ifid_valid_o  = ifid_valid_q;
  assign bus.fault_o       = fault_q;
  assign bus.fetch_count_o = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stimulus queues hand-computed expectations,
// a monitor pops one per clock edge and compares against the registered outputs.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0033;

  logic clk;
  logic rst;
  if_stage_if bus ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational 64-word instruction memory: word i holds 0x1000_0000 + i.
  always_comb bus.imem_data_i = 32'h1000_0000 + {26'd0, bus.imem_addr_o};

  function automatic logic [31:0] w(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  typedef struct {
    int          idx;
    logic [5:0]  addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] cnt;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   step_idx  = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  function automatic exp_t mk(input logic [5:0] addr, input logic [31:0] inst, input logic [31:0] pc,
                              input logic valid, input logic [31:0] cnt, input logic fault);
    exp_t e;
    e.idx = 0; e.addr = addr; e.inst = inst; e.pc = pc; e.valid = valid; e.cnt = cnt; e.fault = fault;
    return e;
  endfunction

  task automatic step(input logic r, input logic st, input logic fl, input logic rd,
                      input logic [31:0] rpc, input exp_t e);
    rst = r; bus.stall_i = st; bus.flush_i = fl; bus.redirect_i = rd; bus.redirect_pc_i = rpc;
    e.idx = step_idx;
    step_idx++;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", e.idx, {26'd0, bus.imem_addr_o}, {26'd0, e.addr});
        chk("ifid_inst", e.idx, bus.ifid_inst_o, e.inst);
        chk("ifid_pc",   e.idx, bus.ifid_pc_o, e.pc);
        chk("ifid_pc4",  e.idx, bus.ifid_pc4_o, e.pc + 32'd4);
        chk("valid",     e.idx, {31'd0, bus.ifid_valid_o}, {31'd0, e.valid});
        chk("count",     e.idx, bus.fetch_count_o, e.cnt);
        chk("fault",     e.idx, {31'd0, bus.fault_o}, {31'd0, e.fault});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst = 1'b1; bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'd0;
    @(negedge clk);
    //    rst   stall flush redir target         addr   inst     pc      v     cnt  f
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd0,  NOP,     32'd0,   1'b0, 0,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd1,  w(0),    32'd0,   1'b1, 1,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd2,  w(1),    32'd4,   1'b1, 2,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd3,  w(2),    32'd8,   1'b1, 3,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd4,  w(3),    32'd12,  1'b1, 4,  1'b0));
    // stall three cycles at pc=16
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, mk(6'd4,  w(3),    32'd12,  1'b1, 4,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd5,  w(4),    32'd16,  1'b1, 5,  1'b0));
    // redirect overrides stall
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'd68,  mk(6'd17, NOP,     32'd20,  1'b0, 5,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd18, w(17),   32'd68,  1'b1, 6,  1'b0));
    // flush alone at pc=40, then flush with stall at pc=48
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd40,  mk(6'd10, NOP,     32'd72,  1'b0, 6,  1'b0));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0,   mk(6'd11, NOP,     32'd40,  1'b0, 6,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd12, w(11),   32'd44,  1'b1, 7,  1'b0));
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0,   mk(6'd12, NOP,     32'd48,  1'b0, 7,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd13, w(12),   32'd48,  1'b1, 8,  1'b0));
    // word-address wrap across pc=256
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd248, mk(6'd62, NOP,     32'd52,  1'b0, 8,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd63, w(62),   32'd248, 1'b1, 9,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd0,  w(63),   32'd252, 1'b1, 10, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd1,  w(0),    32'd256, 1'b1, 11, 1'b0));
    // misaligned redirect: sticky fault, everything frozen
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h42,  mk(6'd1,  NOP,     32'd260, 1'b0, 11, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'd8,   mk(6'd1,  NOP,     32'd260, 1'b0, 11, 1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd1,  NOP,     32'd260, 1'b0, 11, 1'b1));
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0,   mk(6'd1,  NOP,     32'd260, 1'b0, 11, 1'b1));
    // reset wins over a concurrent redirect and clears the fault
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd8,   mk(6'd0,  NOP,     32'd0,   1'b0, 0,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd1,  w(0),    32'd0,   1'b1, 1,  1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,   mk(6'd2,  w(1),    32'd4,   1'b1, 2,  1'b0));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
